studio_keypad: RTL and testbench

- Upstream input stage for the RCA Studio II core.
- Converts MiSTer-style ps2_key events into the two 10-key hex keypads (P1, P2).
- Holds the keypad scan-select latch written by the CDP1802 (OUT 2).
- Drives the EF3/EF4 key-sense flags the CPU polls, and stretches short presses so the game loop sees them.

---
 rtl/studio_kp_pkg.sv | 39 +++
 rtl/studio_key_hold.sv | 49 ++++
 rtl/studio_keypad.sv | 97 +++++++++
 tb/tb_studio_keypad.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/studio_kp_pkg.sv
// Scancode tables and decode helper for the Studio II hex keypads.
// Combinational only; no flow control.
package studio_kp_pkg;

    localparam int KP_KEYS = 10;

    // Packed so that element n is key n (rightmost entry is key 0).
    localparam logic [KP_KEYS-1:0][7:0] P1_CODES = {
        8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
    };
    localparam logic [KP_KEYS-1:0][7:0] P2_CODES = {
        8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73, 8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70
    };

    typedef struct packed {
        logic       valid;
        logic       player;   // 0 = P1, 1 = P2
        logic [3:0] key;
    } kp_code_t;

    function automatic kp_code_t kp_decode(input logic [7:0] scancode);
        kp_code_t r;
        r = '0;
        for (int i = 0; i < KP_KEYS; i++) begin
            if (scancode == P1_CODES[i]) begin
                r.valid  = 1'b1;
                r.player = 1'b0;
                r.key    = 4'(i);
            end
            if (scancode == P2_CODES[i]) begin
                r.valid  = 1'b1;
                r.player = 1'b1;
                r.key    = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/studio_key_hold.sv
// One key: physical state plus a hold counter that stretches short presses.
// effective is registered (1 clk after make/brk); no flow control.
module studio_key_hold #(
    parameter int HOLD_CYCLES = 800000
) (
    input  logic clk,
    input  logic reset,
    input  logic make,
    input  logic brk,
    output logic effective_next,
    output logic effective
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    logic          phys, phys_next;
    logic [CW-1:0] cnt, cnt_next;

    // A break leaves the counter running so a tap still lasts HOLD_CYCLES.
    always_comb begin
        phys_next = phys;
        cnt_next  = cnt;
        if (make) begin
            phys_next = 1'b1;
            cnt_next  = CW'(HOLD_CYCLES);
        end else begin
            if (brk) begin
                phys_next = 1'b0;
            end
            if (cnt != '0) begin
                cnt_next = cnt - 1'b1;
            end
        end
        effective_next = phys_next | (cnt_next != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phys      <= 1'b0;
            cnt       <= '0;
            effective <= 1'b0;
        end else begin
            phys      <= phys_next;
            cnt       <= cnt_next;
            effective <= effective_next;
        end
    end

endmodule

// File: rtl/studio_keypad.sv
// ps2_key events to P1/P2 hex keypads, CPU scan-select latch and EF3/EF4 sense.
// Outputs registered 1 clk after the event/select edge; no backpressure.
module studio_keypad
    import studio_kp_pkg::*;
#(
    parameter int HOLD_CYCLES = 800000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [10:0]         ps2_key,
    input  logic                kp_sel_wr,
    input  logic [3:0]          kp_sel_data,
    output logic                ef3,
    output logic                ef4,
    output logic [KP_KEYS-1:0]  keys_p1,
    output logic [KP_KEYS-1:0]  keys_p2
);

    logic         old_stb, primed;
    logic         key_evt;
    kp_code_t     dec;
    logic [KP_KEYS-1:0] make_p1, brk_p1, make_p2, brk_p2;
    logic [KP_KEYS-1:0] p1_next, p2_next;
    logic [3:0]   sel, sel_next;
    logic [15:0]  p1_pad, p2_pad;

    // The first edge after reset only samples the strobe, so a stale level
    // left over from before reset is never mistaken for a toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            old_stb <= 1'b0;
            primed  <= 1'b0;
        end else begin
            old_stb <= ps2_key[10];
            primed  <= 1'b1;
        end
    end

    // Extended codes dropped so arrow keys do not alias the numeric keypad.
    assign key_evt = primed && (ps2_key[10] != old_stb) && !ps2_key[8];
    assign dec     = kp_decode(ps2_key[7:0]);

    always_comb begin
        make_p1 = '0;
        brk_p1  = '0;
        make_p2 = '0;
        brk_p2  = '0;
        for (int i = 0; i < KP_KEYS; i++) begin
            if (key_evt && dec.valid && dec.key == 4'(i)) begin
                if (!dec.player) begin
                    make_p1[i] = ps2_key[9];
                    brk_p1[i]  = !ps2_key[9];
                end else begin
                    make_p2[i] = ps2_key[9];
                    brk_p2[i]  = !ps2_key[9];
                end
            end
        end
    end

    for (genvar g = 0; g < KP_KEYS; g++) begin : g_keys
        studio_key_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_p1 (
            .clk            (clk),
            .reset          (reset),
            .make           (make_p1[g]),
            .brk            (brk_p1[g]),
            .effective_next (p1_next[g]),
            .effective      (keys_p1[g])
        );
        studio_key_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_p2 (
            .clk            (clk),
            .reset          (reset),
            .make           (make_p2[g]),
            .brk            (brk_p2[g]),
            .effective_next (p2_next[g]),
            .effective      (keys_p2[g])
        );
    end

    assign sel_next = kp_sel_wr ? kp_sel_data : sel;
    // Zero padding makes selects 10..15 read as not pressed.
    assign p1_pad   = {6'b0, p1_next};
    assign p2_pad   = {6'b0, p2_next};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel <= 4'd0;
            ef3 <= 1'b0;
            ef4 <= 1'b0;
        end else begin
            sel <= sel_next;
            ef3 <= p1_pad[sel_next];
            ef4 <= p2_pad[sel_next];
        end
    end

endmodule

// File: tb/tb_studio_keypad.sv
// Directed plus random stimulus for studio_keypad against a timestamp-based model.
module tb_studio_keypad;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = 11'h400;
    logic        kp_sel_wr = 1'b0;
    logic [3:0]  kp_sel_data = 4'd0;
    logic        ef3, ef4;
    logic [9:0]  keys_p1, keys_p2;

    studio_keypad #(.HOLD_CYCLES(HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_key     (ps2_key),
        .kp_sel_wr   (kp_sel_wr),
        .kp_sel_data (kp_sel_data),
        .ef3         (ef3),
        .ef4         (ef4),
        .keys_p1     (keys_p1),
        .keys_p2     (keys_p2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: a key reads pressed while physically held or while
    // fewer than HOLD edges have passed since its most recent make.
    int   p1_tab[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    int   p2_tab[10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    bit   m_phys[20];
    bit   m_made[20];
    int   m_last[20];
    int   m_edge = 0;
    bit   m_primed = 0;
    bit   m_old = 0;
    int   m_sel = 0;
    logic [9:0] e_p1, e_p2;
    logic       e_ef3, e_ef4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 20; i++) begin
            m_phys[i] = 0;
            m_made[i] = 0;
        end
        m_primed = 0;
        m_old = 0;
        m_sel = 0;
    endtask

    task automatic model_outputs();
        for (int k = 0; k < 10; k++) begin
            e_p1[k] = m_phys[k]    || (m_made[k]    && (m_edge - m_last[k])    < HOLD);
            e_p2[k] = m_phys[10+k] || (m_made[10+k] && (m_edge - m_last[10+k]) < HOLD);
        end
        e_ef3 = (m_sel < 10) ? e_p1[m_sel] : 1'b0;
        e_ef4 = (m_sel < 10) ? e_p2[m_sel] : 1'b0;
    endtask

    task automatic model_edge();
        int idx;
        m_edge++;
        if (reset) begin
            model_reset();
        end else begin
            if (kp_sel_wr) m_sel = kp_sel_data;
            if (!m_primed) begin
                m_primed = 1;
            end else if (ps2_key[10] != m_old && !ps2_key[8]) begin
                idx = -1;
                for (int k = 0; k < 10; k++) begin
                    if (int'(ps2_key[7:0]) == p1_tab[k]) idx = k;
                    if (int'(ps2_key[7:0]) == p2_tab[k]) idx = 10 + k;
                end
                if (idx >= 0) begin
                    if (ps2_key[9]) begin
                        m_phys[idx] = 1;
                        m_made[idx] = 1;
                        m_last[idx] = m_edge;
                    end else begin
                        m_phys[idx] = 0;
                    end
                end
            end
            m_old = ps2_key[10];
        end
        model_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("keys_p1", 32'(keys_p1), 32'(e_p1));
        chk("keys_p2", 32'(keys_p2), 32'(e_p2));
        chk("ef3", 32'(ef3), 32'(e_ef3));
        chk("ef4", 32'(ef4), 32'(e_ef4));
        kp_sel_wr = 1'b0;
    endtask

    task automatic set_key(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
        set_key(pressed, ext, code);
        tick();
    endtask

    initial begin
        model_reset();
        model_outputs();
        // Reset state and priming with the strobe held high.
        #2;
        chk("reset_keys_p1", 32'(keys_p1), 32'h0);
        chk("reset_ef3", 32'(ef3), 32'h0);
        chk("reset_ef4", 32'(ef4), 32'h0);
        tick();
        tick();
        #2 reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("prime_keys_p1", 32'(keys_p1), 32'h0);
        chk("prime_ef3", 32'(ef3), 32'h0);

        // Make P1 key 5 together with a select write of 5.
        kp_sel_wr = 1'b1;
        kp_sel_data = 4'd5;
        send(1'b1, 1'b0, 8'h2E);
        chk("make5_keys_p1", 32'(keys_p1), 32'h020);
        chk("make5_ef3", 32'(ef3), 32'h1);
        chk("make5_ef4", 32'(ef4), 32'h0);

        // Break one edge later: held until the 4th edge after the make.
        send(1'b0, 1'b0, 8'h2E);
        chk("hold_e1", 32'(keys_p1[5]), 32'h1);
        tick();
        chk("hold_e2", 32'(keys_p1[5]), 32'h1);
        tick();
        chk("hold_e3", 32'(keys_p1[5]), 32'h1);
        tick();
        chk("hold_e4", 32'(keys_p1[5]), 32'h0);
        chk("hold_e4_ef3", 32'(ef3), 32'h0);

        // Extended 0x75 ignored; plain 0x75 is P2 key 8.
        send(1'b1, 1'b1, 8'h75);
        chk("ext_keys_p2", 32'(keys_p2), 32'h0);
        send(1'b1, 1'b0, 8'h75);
        chk("p2k8_keys_p2", 32'(keys_p2), 32'h100);
        chk("p2k8_ef4_sel5", 32'(ef4), 32'h0);
        kp_sel_wr = 1'b1;
        kp_sel_data = 4'd8;
        tick();
        chk("p2k8_ef4_sel8", 32'(ef4), 32'h1);

        // Out-of-range select, then select and make on the same edge.
        send(1'b1, 1'b0, 8'h45);
        kp_sel_wr = 1'b1;
        kp_sel_data = 4'd12;
        tick();
        chk("sel12_ef3", 32'(ef3), 32'h0);
        chk("sel12_ef4", 32'(ef4), 32'h0);
        send(1'b0, 1'b0, 8'h75);
        kp_sel_wr = 1'b1;
        kp_sel_data = 4'd0;
        send(1'b1, 1'b0, 8'h70);
        chk("same_edge_ef3", 32'(ef3), 32'h1);
        chk("same_edge_ef4", 32'(ef4), 32'h1);

        // All P1 keys down, then asynchronous reset mid-cycle.
        for (int k = 0; k < 10; k++) send(1'b1, 1'b0, 8'(p1_tab[k]));
        chk("all_keys_p1", 32'(keys_p1), 32'h3FF);
        #2 reset = 1'b1;
        model_reset();
        model_outputs();
        #1;
        chk("async_keys_p1", 32'(keys_p1), 32'h0);
        chk("async_keys_p2", 32'(keys_p2), 32'h0);
        chk("async_ef3", 32'(ef3), 32'h0);
        chk("async_ef4", 32'(ef4), 32'h0);
        tick();
        #2 reset = 1'b0;
        send(1'b1, 1'b0, 8'h16);
        chk("reprime_first", 32'(keys_p1), 32'h0);
        send(1'b1, 1'b0, 8'h16);
        chk("reprime_second", 32'(keys_p1), 32'h002);

        // Random traffic: mapped/unmapped codes, extended flag, selects, rare resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [7:0] code;
                case ($urandom_range(0, 4))
                    0, 1:    code = 8'(p1_tab[$urandom_range(0, 9)]);
                    2, 3:    code = 8'(p2_tab[$urandom_range(0, 9)]);
                    default: code = 8'($urandom_range(0, 255));
                endcase
                set_key(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), code);
            end
            if ($urandom_range(0, 3) == 0) begin
                kp_sel_wr = 1'b1;
                kp_sel_data = 4'($urandom_range(0, 15));
            end
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
